// File: rtl/store_monitor.sv
// store_monitor: watches the memory-stage store port of a pipelined processor
// and ends the run on the first store to EXP_ADR, grading the stored value.
// A run-cycle budget (TIMEOUT) ends the run if that store never arrives.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-low reset
//   MemWriteM    in   1   memory-stage write enable
//   DataAdrM     in   32  memory-stage store address
//   WriteDataM   in   32  memory-stage store data
//   state        out  2   00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT
//   done         out  1   high in any terminal state
//   pass         out  1   high only in PASS
//   store_count  out  8   stores seen while running (saturating)
//   cycle_count  out  16  edges spent in RUN
//   last_adr     out  32  address of the latest captured store
//   last_data    out  32  data of the latest captured store
module store_monitor #(
  parameter logic [31:0] EXP_ADR  = 32'd100,
  parameter logic [31:0] EXP_DATA = 32'd7,
  parameter logic [15:0] TIMEOUT  = 16'd25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  output logic [1:0]  state,
  output logic        done,
  output logic        pass,
  output logic [7:0]  store_count,
  output logic [15:0] cycle_count,
  output logic [31:0] last_adr,
  output logic [31:0] last_data
);

  localparam int unsigned ADR_W   = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STORE_W = 8;
  localparam int unsigned CYCLE_W = 16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } stateT;

  stateT currState;

  logic adrHit;
  logic lastRunCycle;

  // Address match only matters when qualified by a write in RUN.
  assign adrHit       = MemWriteM && (DataAdrM == EXP_ADR);
  assign lastRunCycle = (cycle_count == CYCLE_W'(TIMEOUT - 16'd1));

  assign state = currState;

  // Monitor FSM and bookkeeping; terminal states freeze everything until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      currState   <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      store_count <= '0;
      cycle_count <= '0;
      last_adr    <= '0;
      last_data   <= '0;
    end else if (currState == ST_RUN) begin
      cycle_count <= cycle_count + CYCLE_W'(1);

      if (MemWriteM) begin
        last_adr  <= ADR_W'(DataAdrM);
        last_data <= DATA_W'(WriteDataM);
        if (store_count != {STORE_W{1'b1}}) begin
          store_count <= store_count + STORE_W'(1);
        end
      end

      // A graded store wins over the timeout landing on the same edge.
      if (adrHit) begin
        done <= 1'b1;
        if (WriteDataM == EXP_DATA) begin
          currState <= ST_PASS;
          pass      <= 1'b1;
        end else begin
          currState <= ST_FAIL;
          pass      <= 1'b0;
        end
      end else if (lastRunCycle) begin
        currState <= ST_TIMEOUT;
        done      <= 1'b1;
        pass      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_monitor.sv
module tb_store_monitor;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] DataAdrM;
  logic [31:0] WriteDataM;

  logic [1:0]  stateA,  stateB;
  logic        doneA,   doneB;
  logic        passA,   passB;
  logic [7:0]  storeA,  storeB;
  logic [15:0] cycleA,  cycleB;
  logic [31:0] ladrA,   ladrB;
  logic [31:0] ldatA,   ldatB;

  int tests;
  int fails;

  store_monitor dutA (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .DataAdrM   (DataAdrM),
    .WriteDataM (WriteDataM),
    .state      (stateA),
    .done       (doneA),
    .pass       (passA),
    .store_count(storeA),
    .cycle_count(cycleA),
    .last_adr   (ladrA),
    .last_data  (ldatA)
  );

  store_monitor #(.TIMEOUT(16'd400)) dutB (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .DataAdrM   (DataAdrM),
    .WriteDataM (WriteDataM),
    .state      (stateB),
    .done       (doneB),
    .pass       (passB),
    .store_count(storeB),
    .cycle_count(cycleB),
    .last_adr   (ladrB),
    .last_data  (ldatB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so inputs change away from the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkA(input string tag, input logic [1:0] st, input logic dn, input logic ps,
                      input logic [7:0] sc, input logic [15:0] cc,
                      input logic [31:0] la, input logic [31:0] ld);
    chk({tag, ".state"},       32'(stateA), 32'(st));
    chk({tag, ".done"},        32'(doneA),  32'(dn));
    chk({tag, ".pass"},        32'(passA),  32'(ps));
    chk({tag, ".store_count"}, 32'(storeA), 32'(sc));
    chk({tag, ".cycle_count"}, 32'(cycleA), 32'(cc));
    chk({tag, ".last_adr"},    ladrA,       la);
    chk({tag, ".last_data"},   ldatA,       ld);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWriteM  = 1'b1;
    DataAdrM   = a;
    WriteDataM = d;
  endtask

  task automatic idle();
    MemWriteM  = 1'b0;
    DataAdrM   = 32'hDEAD_BEEF;
    WriteDataM = 32'h1234_5678;
  endtask

  task automatic doReset();
    idle();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    idle();
    step(2);
    chkA("reset", 2'b00, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0, 32'd0);

    // Held reset ignores a matching store.
    store(32'd100, 32'd7);
    step(1);
    chkA("hold_reset", 2'b00, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0, 32'd0);

    // Pass at run cycle 5.
    reset = 1'b1;
    idle();
    step(4);
    chkA("run4", 2'b00, 1'b0, 1'b0, 8'd0, 16'd4, 32'd0, 32'd0);
    store(32'd100, 32'd7);
    step(1);
    chkA("pass", 2'b01, 1'b1, 1'b1, 8'd1, 16'd5, 32'd100, 32'd7);

    // Terminal state ignores further stores.
    store(32'd100, 32'd8);
    step(3);
    chkA("pass_sticky", 2'b01, 1'b1, 1'b1, 8'd1, 16'd5, 32'd100, 32'd7);

    // Reset beats a matching store on the same edge, then PASS again.
    reset = 1'b0;
    store(32'd100, 32'd7);
    step(1);
    chkA("reset_over_store", 2'b00, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0, 32'd0);
    reset = 1'b1;
    step(1);
    chkA("repass", 2'b01, 1'b1, 1'b1, 8'd1, 16'd1, 32'd100, 32'd7);

    // Wrong data at the watched address.
    doReset();
    store(32'd100, 32'd8);
    step(1);
    chkA("fail", 2'b10, 1'b1, 1'b0, 8'd1, 16'd1, 32'd100, 32'd8);

    // Other addresses only, then timeout after 25 run cycles.
    doReset();
    store(32'd96, 32'd1);
    step(1);
    chkA("st96", 2'b00, 1'b0, 1'b0, 8'd1, 16'd1, 32'd96, 32'd1);
    store(32'd104, 32'd2);
    step(1);
    idle();
    step(22);
    chkA("pre_timeout", 2'b00, 1'b0, 1'b0, 8'd2, 16'd24, 32'd104, 32'd2);
    step(1);
    chkA("timeout", 2'b11, 1'b1, 1'b0, 8'd2, 16'd25, 32'd104, 32'd2);
    step(5);
    chkA("timeout_sticky", 2'b11, 1'b1, 1'b0, 8'd2, 16'd25, 32'd104, 32'd2);

    // Matching store on the timeout edge: PASS wins.
    doReset();
    step(24);
    store(32'd100, 32'd7);
    step(1);
    chkA("pass_on_timeout_edge", 2'b01, 1'b1, 1'b1, 8'd1, 16'd25, 32'd100, 32'd7);

    // Mismatching store on the timeout edge: FAIL wins.
    doReset();
    step(24);
    store(32'd100, 32'd9);
    step(1);
    chkA("fail_on_timeout_edge", 2'b10, 1'b1, 1'b0, 8'd1, 16'd25, 32'd100, 32'd9);

    // Reset beats the timeout edge.
    doReset();
    step(24);
    reset = 1'b0;
    step(1);
    chkA("reset_over_timeout", 2'b00, 1'b0, 1'b0, 8'd0, 16'd0, 32'd0, 32'd0);
    reset = 1'b1;

    // Store-count saturation on the long-budget instance.
    doReset();
    for (int i = 1; i <= 255; i++) begin
      store(32'd0, 32'(i));
      step(1);
    end
    chk("sat255.store_count", 32'(storeB), 32'd255);
    chk("sat255.cycle_count", 32'(cycleB), 32'd255);
    chk("sat255.last_data",   ldatB,       32'd255);
    for (int i = 256; i <= 300; i++) begin
      store(32'd0, 32'(i));
      step(1);
    end
    chk("sat300.store_count", 32'(storeB), 32'd255);
    chk("sat300.cycle_count", 32'(cycleB), 32'd300);
    chk("sat300.state",       32'(stateB), 32'd0);
    chk("sat300.last_data",   ldatB,       32'd300);
    // Short-budget instance froze on its 25th edge with 25 stores counted.
    chkA("short_budget_frozen", 2'b11, 1'b1, 1'b0, 8'd25, 16'd25, 32'd0, 32'd25);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
